eth_frame_stamper: RTL and testbench

ETH_FRAME_STAMPER -- requirements
Module: eth_frame_stamper

---
 rtl/eth_frame_stamper_if.sv | 31 +++
 rtl/eth_frame_stamper.sv | 163 ++++++++++++++++
 tb/tb_eth_frame_stamper.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_stamper_if.sv
// Bus bundle for eth_frame_stamper: RX byte stream in, registered copy out, metadata record stream out.
// The slave modport is the stamper's view; master is the surrounding system's view.
interface eth_frame_stamper_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;

  logic [7:0]  m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;

  logic [95:0] m_axis_meta_tdata;
  logic        m_axis_meta_tvalid;
  logic        m_axis_meta_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output m_axis_meta_tdata, m_axis_meta_tvalid,
    input  m_axis_meta_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input  m_axis_meta_tdata, m_axis_meta_tvalid,
    output m_axis_meta_tready
  );
endinterface

// File: rtl/eth_frame_stamper.sv
// Purpose: registered RX passthrough plus one {timestamp,length,flags} record per frame; ETH_FRAME_STAMPER_DROP_CNT_EN enables drop_count.
// Latency: data 1 cycle; record pushed the cycle after tlast, visible on meta stream one cycle later.
// Backpressure: none on RX; meta stalls into a FWFT FIFO, records arriving while it is full are dropped.
module eth_frame_stamper #(
  parameter int META_FIFO_DEPTH = 8
) (
  input  logic                 s_axis_clk,
  input  logic                 s_axis_resetn,
  eth_frame_stamper_if.slave   bus,
  input  logic [63:0]          current_time,
  input  logic                 time_running,
  output logic [31:0]          drop_count
);

  localparam int          AW       = $clog2(META_FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(META_FIFO_DEPTH);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  // Assertion is immediate; release is retimed so no flop sees a reset edge near the clock.
  logic rst_meta;
  logic rst_n;

  always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  always_ff @(posedge s_axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tuser  <= 1'b0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
    end else begin
      bus.m_axis_tdata  <= bus.s_axis_tdata;
      bus.m_axis_tuser  <= bus.s_axis_tuser;
      bus.m_axis_tlast  <= bus.s_axis_tlast;
      bus.m_axis_tvalid <= bus.s_axis_tvalid;
    end
  end

  state_t      state_q, state_d;
  logic [63:0] ts_q, ts_d;
  logic [15:0] len_q, len_d;
  logic        stop_q, stop_d;
  logic        sat_q, sat_d;
  logic        push_vld_q, push_vld_d;
  logic [95:0] push_dat_q, push_dat_d;

  always_ff @(posedge s_axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      len_q      <= '0;
      stop_q     <= 1'b0;
      sat_q      <= 1'b0;
      push_vld_q <= 1'b0;
      push_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      len_q      <= len_d;
      stop_q     <= stop_d;
      sat_q      <= sat_d;
      push_vld_q <= push_vld_d;
      push_dat_q <= push_dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    len_d      = len_q;
    stop_d     = stop_q;
    sat_d      = sat_q;
    push_vld_d = 1'b0;
    push_dat_d = '0;
    if (bus.s_axis_tvalid) begin
      if (state_q == IDLE) begin
        ts_d   = current_time;
        len_d  = 16'd1;
        stop_d = ~time_running;
        sat_d  = 1'b0;
      end else if (len_q == 16'hFFFF) begin
        sat_d = 1'b1;
      end else begin
        len_d = len_q + 16'd1;
      end
      if (bus.s_axis_tlast) begin
        push_vld_d = 1'b1;
        push_dat_d = {ts_d, len_d, 13'd0, sat_d, stop_d, bus.s_axis_tuser};
        state_d    = IDLE;
      end else begin
        state_d = IN_FRAME;
      end
    end
  end

  logic [95:0]   mem [META_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = ~empty & bus.m_axis_meta_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = push_vld_q & (~full | pop);

  assign bus.m_axis_meta_tvalid = ~empty;
  assign bus.m_axis_meta_tdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge s_axis_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat_q;
    end
  end

  always_ff @(posedge s_axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ETH_FRAME_STAMPER_DROP_CNT_EN
  logic drop;
  assign drop = push_vld_q & full & ~pop;

  always_ff @(posedge s_axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 32'hFFFF_FFFF)) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_eth_frame_stamper.sv
// Directed bench for eth_frame_stamper: passthrough monitor plus a queue of expected metadata records.
module tb_eth_frame_stamper;

`ifdef ETH_FRAME_STAMPER_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [63:0] current_time;
  logic        time_running;
  logic [31:0] drop_count;

  eth_frame_stamper_if bus();

  eth_frame_stamper #(.META_FIFO_DEPTH(8)) dut (
    .s_axis_clk    (clk),
    .s_axis_resetn (rst_n),
    .bus           (bus),
    .current_time  (current_time),
    .time_running  (time_running),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          pops   = 0;
  logic [95:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          pt_arm = 1'b0;
  logic        pv, pu, pl;
  logic [7:0]  pd;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    current_time = current_time + 64'd1;
  endtask

  function automatic logic [95:0] rec(input logic [63:0] ts, input int len, input bit tuser, input bit stopped);
    logic [15:0] l;
    bit          sat;
    sat = (len > 65535);
    l   = sat ? 16'hFFFF : 16'(len);
    return {ts, l, 13'd0, sat, stopped, tuser};
  endfunction

  task automatic send_frame(input int len, input bit tuser, input bit running, input int gap_at, input bit keep);
    logic [63:0] ts;
    ts = current_time;
    time_running = running;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at && i > 0) begin
        bus.s_axis_tvalid = 1'b0;
        tick();
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = 8'($urandom);
      bus.s_axis_tlast  = (i == len - 1);
      bus.s_axis_tuser  = (i == len - 1) ? tuser : 1'($urandom_range(0, 1));
      tick();
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    if (keep) exp_q.push_back(rec(ts, len, tuser, ~running));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.m_axis_meta_tvalid); i++) tick();
    check(tag, {95'd0, (exp_q.size() == 0 && !bus.m_axis_meta_tvalid)}, 96'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
    check({tag, "_tdata"}, bus.m_axis_tdata, 0);
    check({tag, "_tuser"}, bus.m_axis_tuser, 0);
    check({tag, "_tlast"}, bus.m_axis_tlast, 0);
    check({tag, "_meta_tvalid"}, bus.m_axis_meta_tvalid, 0);
    check({tag, "_meta_tdata"}, bus.m_axis_meta_tdata, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  // Passthrough model and metadata consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && pt_arm) begin
      check("pt_tvalid", bus.m_axis_tvalid, pv);
      if (pv) begin
        check("pt_tdata", bus.m_axis_tdata, pd);
        check("pt_tuser", bus.m_axis_tuser, pu);
        check("pt_tlast", bus.m_axis_tlast, pl);
      end
    end
    pt_arm = mon_en;
    pv = bus.s_axis_tvalid;
    pd = bus.s_axis_tdata;
    pu = bus.s_axis_tuser;
    pl = bus.s_axis_tlast;
    if (bus.m_axis_meta_tvalid && bus.m_axis_meta_tready) begin
      pops++;
      check("meta_expected", {95'd0, exp_q.size() != 0}, 96'd1);
      if (exp_q.size() != 0) check("meta_record", bus.m_axis_meta_tdata, exp_q.pop_front());
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tuser  = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_meta_tready = 1'b0;
    time_running = 1'b1;
    current_time = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");

    rst_n = 1'b1;
    repeat (4) tick();
    mon_en = 1'b1;
    bus.m_axis_meta_tready = 1'b1;

    // 64-byte frame starting at time 100
    current_time = 64'd100;
    send_frame(64, 1'b0, 1'b1, -1, 1'b0);
    exp_q.push_back({64'd100, 16'd64, 16'h0000});
    wait_drain("drain_64B");

    // single-beat bad frame with the timer stopped
    current_time = 64'd7;
    send_frame(1, 1'b1, 1'b0, -1, 1'b0);
    exp_q.push_back({64'd7, 16'd1, 16'h0003});
    wait_drain("drain_single");

    // gaps inside frames, then back-to-back frames
    send_frame(10, 1'b0, 1'b1, 4, 1'b1);
    send_frame(5, 1'b1, 1'b1, -1, 1'b1);
    send_frame(1, 1'b0, 1'b0, -1, 1'b1);
    send_frame(7, 1'b0, 1'b1, 2, 1'b1);
    wait_drain("drain_b2b");

    // nine frames into an eight-deep FIFO with the consumer stalled
    bus.m_axis_meta_tready = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(3, 1'(i), 1'b1, -1, i < 8);
    repeat (4) tick();
    check("stall_tvalid", bus.m_axis_meta_tvalid, 1);
    check("stall_hold_a", bus.m_axis_meta_tdata, exp_q[0]);
    repeat (5) tick();
    check("stall_hold_b", bus.m_axis_meta_tdata, exp_q[0]);
    check("drop_count_9", drop_count, DROP_EN ? 1 : 0);
    p0 = pops;
    bus.m_axis_meta_tready = 1'b1;
    wait_drain("drain_stall");
    check("pops_stall", pops - p0, 8);

    // push and pop in the same cycle with the FIFO full
    bus.m_axis_meta_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(1, 1'b0, 1'b1, -1, 1'b1);
    repeat (3) tick();
    p0 = pops;
    send_frame(1, 1'b1, 1'b1, -1, 1'b1);
    bus.m_axis_meta_tready = 1'b1;
    tick();
    bus.m_axis_meta_tready = 1'b0;
    repeat (2) tick();
    check("simul_tvalid", bus.m_axis_meta_tvalid, 1);
    check("simul_no_drop", drop_count, DROP_EN ? 1 : 0);
    send_frame(2, 1'b0, 1'b1, -1, 1'b0);
    repeat (3) tick();
    check("still_full_drop", drop_count, DROP_EN ? 2 : 0);
    bus.m_axis_meta_tready = 1'b1;
    wait_drain("drain_simul");
    check("pops_simul", pops - p0, 9);

    // length saturation, then a normal frame
    send_frame(70000, 1'b0, 1'b1, -1, 1'b1);
    send_frame(4, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("drain_sat");

    // reset in the middle of a 60-beat frame; the 30-beat tail becomes its own frame
    for (int i = 0; i < 30; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = 8'($urandom);
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tuser  = 1'b0;
      tick();
    end
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    bus.s_axis_tvalid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    mon_en = 1'b1;
    send_frame(30, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("drain_tail");
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
